bldc_ctrl_regfile: RTL and testbench
====================================

Name: bldc_ctrl_regfile

Overview:
- Host-facing register block for the BLDC motor controller.
- Holds the control word (velocity, PWM duty, enable) written over a simple 1-bit-address bus, and returns a status word that includes the Hall/commutation phase.
- Converts the velocity code to a one-hot select and looks up the commutation step period T (in clk cycles), which feeds the commutation FSM and PWM stages.

Parameters:
- T_BASE, 500000, step period in clk cycles for velocity code 1 (50 MHz clock → 10 ms); T for code k = T_BASE / k, integer-truncated.

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst  in  1  asynchronous, active-low reset
- write  in  1  write strobe, sampled on rising clk
- read  in  1  read strobe, sampled on rising clk
- addr  in  1  register select: 0 = CTRL, 1 = STATUS
- data_in  in  32  write data
- data_out  out  32  registered read data
- phase_state  in  3  current commutation phase from the FSM
- vel  out  8  velocity code (CTRL[31:24])
- duty  out  8  PWM duty (CTRL[23:16])
- en  out  1  motor enable (CTRL[15])
- vel_onehot  out  8  one-hot decode of vel[2:0]
- T  out  32  commutation step period in clk cycles

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release): vel=0, duty=0, en=0, data_out=0. vel_onehot=8'h01 and T=0 follow combinationally.
- CTRL register (addr 0):
  - On a rising edge with write=1 and addr=0: vel←data_in[31:24], duty←data_in[23:16], en←data_in[15].
  - data_in[14:0] is ignored.
  - New values appear on vel/duty/en one cycle after the write edge.
- Writes with addr=1 are ignored; STATUS is read-only.
- Read, 1-cycle latency: on a rising edge with read=1, data_out is loaded with the selected word; otherwise data_out holds its value.
  - addr=0 → {vel, duty, en, 15'b0}.
  - addr=1 → {vel, duty, en, 12'b0, phase_state}. phase_state is sampled at the read edge.
- Simultaneous write and read to addr 0 on the same edge: data_out returns the pre-write contents (read-before-write).
- One-hot decode (combinational): vel_onehot = 1 << vel[2:0]. vel[7:3] is ignored for the lookup.
- Lookup (combinational on vel_onehot):
  - bit0 → 0 (stopped)
  - bit1 → 500000
  - bit2 → 250000
  - bit3 → 166666
  - bit4 → 125000
  - bit5 → 100000
  - bit6 → 83333
  - bit7 → 71428
  - Any non-one-hot input (zero or multiple bits set) → T=0.
- en does not gate T or duty; downstream blocks qualify with en.
- Reset asserted mid-operation: all registers clear immediately; any in-flight read or write is discarded.

Decomposition:
- Shared package bldc_pkg holds:
  - register address constants ADDR_CTRL=0 and ADDR_STATUS=1;
  - CTRL field bit positions (VEL_MSB=31, DUTY_MSB=23, EN_BIT=15);
  - T_BASE and the eight T constants.
- One sub-module is natural: bldc_period_lut (combinational one-hot → T table, including the invalid-input → 0 rule).
- Top-level holds the registers, read mux and binary→one-hot decode.

Test Plan:
- Reset, then hold write=read=0 → vel=duty=0, en=0, data_out=0, vel_onehot=8'h01, T=0.
- phase_state=3'b011. Write addr0 data_in=0x03408000 (vel=3, duty=64, en=1), then read addr1:
  - after the write: vel=3, duty=64, en=1, T=166666;
  - after the read: data_out=0x03408003.
- Duty sweep with vel=3, en=1, duty=0/64/128/192 → T stays 166666; STATUS reads 0x03008003, 0x03408003, 0x03808003, 0x03C08003.
- Velocity sweep 0..7 with duty=128, en=1 → T = 0, 500000, 250000, 166666, 125000, 100000, 83333, 71428; vel_onehot = 1<<v.
- Write to addr1 with data_in=0xFFFFFFFF → CTRL unchanged. Write vel=9 → vel=9, vel_onehot=8'h02, T=500000. Same-edge write+read at addr0 → data_out returns the old CTRL.
- Assert rst low between clock edges after loading CTRL → vel, duty, en and data_out clear to 0 without waiting for a clock edge; T=0.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared constants for the BLDC controller register block: register map,
// CTRL field positions and the commutation step-period table.
package bldc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned VEL_W   = 8;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned SEL_W   = 8;

  localparam logic ADDR_CTRL   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int unsigned VEL_MSB  = 31;
  localparam int unsigned DUTY_MSB = 23;
  localparam int unsigned EN_BIT   = 15;

  localparam int unsigned T_BASE = 500000;

  localparam logic [DATA_W-1:0] T_STOP = 32'd0;
  localparam logic [DATA_W-1:0] T_VEL1 = 32'(T_BASE / 1);
  localparam logic [DATA_W-1:0] T_VEL2 = 32'(T_BASE / 2);
  localparam logic [DATA_W-1:0] T_VEL3 = 32'(T_BASE / 3);
  localparam logic [DATA_W-1:0] T_VEL4 = 32'(T_BASE / 4);
  localparam logic [DATA_W-1:0] T_VEL5 = 32'(T_BASE / 5);
  localparam logic [DATA_W-1:0] T_VEL6 = 32'(T_BASE / 6);
  localparam logic [DATA_W-1:0] T_VEL7 = 32'(T_BASE / 7);

endpackage

// File: rtl/bldc_period_lut.sv
// One-hot velocity select to commutation step period; anything that is not
// exactly one-hot yields a stopped (zero) period.
module bldc_period_lut
  import bldc_pkg::*;
(
  input  logic [7:0]  sel,
  output logic [31:0] period
);

  always_comb begin
    period = T_STOP;
    case (sel)
      8'b0000_0001: period = T_STOP;
      8'b0000_0010: period = T_VEL1;
      8'b0000_0100: period = T_VEL2;
      8'b0000_1000: period = T_VEL3;
      8'b0001_0000: period = T_VEL4;
      8'b0010_0000: period = T_VEL5;
      8'b0100_0000: period = T_VEL6;
      8'b1000_0000: period = T_VEL7;
      default:      period = T_STOP;
    endcase
  end

endmodule

// File: rtl/bldc_ctrl_regfile.sv
// Host register block for the BLDC controller: CTRL register, read mux with
// STATUS (including commutation phase), velocity decode and period lookup.
module bldc_ctrl_regfile
  import bldc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        read,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [2:0]  phase_state,
  output logic [7:0]  vel,
  output logic [7:0]  duty,
  output logic        en,
  output logic [7:0]  vel_onehot,
  output logic [31:0] T
);

  logic [DATA_W-1:0] ctrl_word;
  logic [DATA_W-1:0] status_word;
  logic              unused_data_bits;

  // Low CTRL bits carry no state.
  assign unused_data_bits = ^data_in[EN_BIT-1:0];

  assign ctrl_word   = {vel, duty, en, 15'b0};
  assign status_word = {vel, duty, en, 12'b0, phase_state};

  // Register update; the read mux sees pre-write values on a shared edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vel      <= '0;
      duty     <= '0;
      en       <= 1'b0;
      data_out <= '0;
    end else begin
      if (write && (addr == ADDR_CTRL)) begin
        vel  <= data_in[VEL_MSB -: VEL_W];
        duty <= data_in[DUTY_MSB -: DUTY_W];
        en   <= data_in[EN_BIT];
      end
      if (read) begin
        data_out <= (addr == ADDR_STATUS) ? status_word : ctrl_word;
      end
    end
  end

  assign vel_onehot = 8'b0000_0001 << vel[2:0];

  bldc_period_lut u_period_lut (
    .sel    (vel_onehot),
    .period (T)
  );

endmodule

// File: tb/tb_bldc_ctrl_regfile.sv
// Directed bench for bldc_ctrl_regfile: read responses go through a scoreboard
// queue checked by a monitor; control outputs are checked inline.
module tb_bldc_ctrl_regfile;

  logic        clk;
  logic        rst;
  logic        write;
  logic        read;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [2:0]  phase_state;
  logic [7:0]  vel;
  logic [7:0]  duty;
  logic        en;
  logic [7:0]  vel_onehot;
  logic [31:0] T;

  int checks;
  int failures;
  logic [31:0] sb_q[$];
  logic read_seen;

  bldc_ctrl_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .phase_state (phase_state),
    .vel         (vel),
    .duty        (duty),
    .en          (en),
    .vel_onehot  (vel_onehot),
    .T           (T)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Tracks which edges launched a read so the monitor knows when to pop.
  always @(posedge clk or negedge rst) begin
    if (!rst) read_seen <= 1'b0;
    else      read_seen <= read;
  end

  always @(negedge clk) begin
    if (rst && read_seen) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected: got 0x%08h expected none", data_out);
      end else begin
        chk("read_data", data_out, sb_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic a, input logic [31:0] exp);
    @(negedge clk);
    read = 1'b1; addr = a;
    sb_q.push_back(exp);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  logic [31:0] duty_status [4] = '{32'h0340_8003, 32'h0340_8003, 32'h0380_8003, 32'h03C0_8003};
  logic [7:0]  duty_vals   [4] = '{8'd0, 8'd64, 8'd128, 8'd192};
  logic [31:0] t_table     [8] = '{32'd0, 32'd500000, 32'd250000, 32'd166666,
                                   32'd125000, 32'd100000, 32'd83333, 32'd71428};
  logic [7:0]  oh_table    [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    checks = 0; failures = 0;
    duty_status[0] = 32'h0300_8003;
    rst = 1'b0; write = 1'b0; read = 1'b0; addr = 1'b0;
    data_in = '0; phase_state = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_vel", 32'(vel), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_onehot", 32'(vel_onehot), 32'h01);
    chk("rst_T", T, 32'd0);

    phase_state = 3'b011;
    do_write(1'b0, 32'h0340_8000);
    chk("wr_vel", 32'(vel), 32'd3);
    chk("wr_duty", 32'(duty), 32'd64);
    chk("wr_en", 32'(en), 32'd1);
    chk("wr_T", T, 32'd166666);
    do_read(1'b1, 32'h0340_8003);
    drain();

    for (int i = 0; i < 4; i++) begin
      do_write(1'b0, {8'd3, duty_vals[i], 1'b1, 15'b0});
      chk("duty_sweep_T", T, 32'd166666);
      do_read(1'b1, duty_status[i]);
    end
    drain();

    for (int v = 0; v < 8; v++) begin
      do_write(1'b0, {8'(v), 8'd128, 1'b1, 15'h1234});
      chk("vel_sweep_T", T, t_table[v]);
      chk("vel_sweep_onehot", 32'(vel_onehot), 32'(oh_table[v]));
      do_read(1'b0, {8'(v), 8'd128, 1'b1, 15'b0});
    end
    drain();

    do_write(1'b1, 32'hFFFF_FFFF);
    chk("status_wr_vel", 32'(vel), 32'd7);
    chk("status_wr_duty", 32'(duty), 32'd128);
    chk("status_wr_en", 32'(en), 32'd1);
    do_read(1'b0, 32'h0780_8000);

    do_write(1'b0, 32'h0910_8000);
    chk("vel9_vel", 32'(vel), 32'd9);
    chk("vel9_onehot", 32'(vel_onehot), 32'h02);
    chk("vel9_T", T, 32'd500000);

    @(negedge clk);
    write = 1'b1; read = 1'b1; addr = 1'b0; data_in = 32'h0520_0000;
    sb_q.push_back(32'h0910_8000);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("rw_vel", 32'(vel), 32'd5);
    chk("rw_en", 32'(en), 32'd0);
    chk("rw_T", T, 32'd100000);
    do_read(1'b0, 32'h0520_0000);
    drain();

    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_vel", 32'(vel), 32'd0);
    chk("async_rst_duty", 32'(duty), 32'd0);
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_data_out", data_out, 32'd0);
    chk("async_rst_onehot", 32'(vel_onehot), 32'h01);
    chk("async_rst_T", T, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
